triangle_bbox_scanner: RTL
==========================

Name: triangle_bbox_scanner

Overview:
- Raster point generator upstream of the point-in-triangle tester.
- Captures three signed triangle vertices and computes their axis-aligned bounding box, clipped to the screen.
- Emits every pixel coordinate in the clipped box in raster order over a valid/ready handshake; its pt_x/pt_y drive the tester's PTX/PTY.
- Pulses done when the scan completes.

Parameters:
- W, 12, coordinate width in bits; vertices are two's-complement signed.
- SCREEN_W, 640, screen width in pixels; valid x range is 0..SCREEN_W-1.
- SCREEN_H, 480, screen height in pixels; valid y range is 0..SCREEN_H-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- p1x, p1y, p2x, p2y, p3x, p3y  in  W each  signed vertex coordinates; sampled only on the accepted start edge.
- busy  out  1  high in BBOX, CLIP and SCAN.
- pt_x  out  W  current point x, unsigned, in 0..SCREEN_W-1.
- pt_y  out  W  current point y, unsigned, in 0..SCREEN_H-1.
- pt_valid  out  1  pt_x/pt_y hold a valid point.
- pt_ready  in  1  consumer accepts the point; a handshake occurs when pt_valid && pt_ready.
- pt_last  out  1  the current point is the final point of the box; meaningful only while pt_valid is high.
- done  out  1  one-cycle pulse marking the end of a scan.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE; busy, pt_valid, pt_last and done are 0; pt_x and pt_y are 0.
- Reset mid-operation aborts the scan immediately. No done pulse is produced.
- States are IDLE, BBOX, CLIP, SCAN and DONE.
- IDLE:
  - start=1 registers all six vertices and moves to BBOX.
  - start is ignored in every other state.
- BBOX (one cycle): signed min/max over the three x values and over the three y values.
- CLIP (one cycle):
  - xmin = max(minx, 0); xmax = min(maxx, SCREEN_W-1); ymin and ymax likewise against SCREEN_H-1.
  - All comparisons are signed at W bits; SCREEN_W-1 and SCREEN_H-1 must fit in W-1 bits.
  - If xmin > xmax or ymin > ymax the box is empty: go to DONE without emitting any point.
  - Otherwise load pt_x=xmin and pt_y=ymin, and go to SCAN.
- Latency: with start high in cycle N, busy is high from N+1 and pt_valid is high from N+3 (first point). For an empty box, done is high in N+3.
- SCAN:
  - pt_valid=1 throughout.
  - pt_x/pt_y are held stable while pt_ready=0.
  - On each handshake, if pt_x < xmax then pt_x increments. Otherwise pt_x returns to xmin and pt_y increments.
  - pt_last = (pt_x==xmax && pt_y==ymax), combinational from the registers.
  - A handshake while pt_last is high moves to DONE and drops pt_valid the next cycle.
  - Each point is emitted exactly once: no skips, no duplicates.
  - A one-pixel box (xmin==xmax, ymin==ymax) emits a single point with pt_last=1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Point count per scan is (xmax-xmin+1)*(ymax-ymin+1).
- Throughput: with pt_ready held high, one point per cycle.

Test Plan:
- Vertices (2,15),(16,3),(29,4), pt_ready=1 -> 364 points (x 2..29, y 3..15). First (2,3), x wraps 29->2 with y+1, pt_last only on (29,15), done one cycle after the last handshake.
- Vertices (-17,-4),(5,15),(-43,20) -> clipped box x 0..5, y 0..20. 126 points, first (0,0), last (21st row) (5,20).
- Vertices (-30,1),(-2,5),(-9,9), fully left of screen -> no pt_valid ever. done high 3 cycles after start, busy high for exactly 2 cycles.
- Box from the first scenario with pt_ready pseudo-random (~50% duty) -> pt_x/pt_y stable across stall cycles, sequence identical to the first scenario, 364 handshakes. A start pulse mid-scan has no effect.
- Degenerate triangle (7,7) ×3 -> exactly one point (7,7) with pt_last=1, then a done pulse.
- Assert rst during SCAN at point (10,5) -> all outputs 0 within the reset cycle, no done pulse. A new start after release rescans from (2,3).

Source files
------------

// File: rtl/triangle_bbox_scanner.sv
// Raster point generator: captures a signed triangle, clips its bounding box to
// the screen and streams every pixel of the box in raster order over valid/ready.
module triangle_bbox_scanner #(
  parameter int W        = 12,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] p1x,
  input  logic [W-1:0] p1y,
  input  logic [W-1:0] p2x,
  input  logic [W-1:0] p2y,
  input  logic [W-1:0] p3x,
  input  logic [W-1:0] p3y,
  output logic         busy,
  output logic [W-1:0] pt_x,
  output logic [W-1:0] pt_y,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic         pt_last,
  output logic         done
);

  localparam logic signed [W-1:0] ZERO = '0;
  localparam logic signed [W-1:0] X_HI = W'(SCREEN_W - 1);
  localparam logic signed [W-1:0] Y_HI = W'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, BBOX, CLIP, SCAN, DONE} state_t;

  state_t state, state_d;

  logic signed [W-1:0] vx0, vx1, vx2, vy0, vy1, vy2;
  logic signed [W-1:0] minx, maxx, miny, maxy;
  logic signed [W-1:0] cxmin, cxmax, cymin, cymax;
  logic        [W-1:0] xmin, xmax, ymax;
  logic                empty_c;
  logic                hs_c;

  function automatic logic signed [W-1:0] smin(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Screen clipping of the registered bounding box; an inverted range means nothing is visible.
  always_comb begin
    cxmin   = (minx < ZERO) ? ZERO : minx;
    cxmax   = (maxx > X_HI) ? X_HI : maxx;
    cymin   = (miny < ZERO) ? ZERO : miny;
    cymax   = (maxy > Y_HI) ? Y_HI : maxy;
    empty_c = (cxmin > cxmax) || (cymin > cymax);
  end

  assign hs_c    = pt_valid && pt_ready;
  assign pt_last = pt_valid && (pt_x == xmax) && (pt_y == ymax);

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = BBOX;
      BBOX:    state_d = CLIP;
      CLIP:    state_d = empty_c ? DONE : SCAN;
      SCAN:    if (hs_c && pt_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; status flags are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      pt_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      busy     <= (state_d == BBOX) || (state_d == CLIP) || (state_d == SCAN);
      pt_valid <= (state_d == SCAN);
      done     <= (state_d == DONE);
    end
  end

  // Vertex capture, bounding box, clip registers and raster walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx0  <= '0;
      vx1  <= '0;
      vx2  <= '0;
      vy0  <= '0;
      vy1  <= '0;
      vy2  <= '0;
      minx <= '0;
      maxx <= '0;
      miny <= '0;
      maxy <= '0;
      xmin <= '0;
      xmax <= '0;
      ymax <= '0;
      pt_x <= '0;
      pt_y <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vx0 <= p1x;
            vx1 <= p2x;
            vx2 <= p3x;
            vy0 <= p1y;
            vy1 <= p2y;
            vy2 <= p3y;
          end
        end
        BBOX: begin
          minx <= smin(smin(vx0, vx1), vx2);
          maxx <= smax(smax(vx0, vx1), vx2);
          miny <= smin(smin(vy0, vy1), vy2);
          maxy <= smax(smax(vy0, vy1), vy2);
        end
        CLIP: begin
          xmin <= cxmin;
          xmax <= cxmax;
          ymax <= cymax;
          pt_x <= cxmin;
          pt_y <= cymin;
        end
        SCAN: begin
          // The final point is left in place; the walk only advances inside the box.
          if (hs_c && !pt_last) begin
            if (pt_x != xmax) begin
              pt_x <= pt_x + W'(1);
            end else begin
              pt_x <= xmin;
              pt_y <= pt_y + W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
